// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the synchronous-read I-mem and hands
// fetched words to ID through a one-entry skid buffer so stalls never drop or repeat a word.
module fetch_stage #(
    parameter int          ADDR_W   = 9,
    parameter int          INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_dout,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc
);

    logic [31:0]        pc;
    logic               inflight;
    logic [31:0]        inflight_pc;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0]        skid_pc;
    logic               out_take;
    logic               issue;

    // Handshake: a word transfers to ID at a rising edge where if_id_valid and id_ready are
    // both high; while if_id_valid is high and id_ready is low the output register is frozen.
    assign out_take = ~if_id_valid | id_ready;

    // Only issue when the returning word is guaranteed a home (output or empty skid).
    assign issue     = run_en & ~redirect_valid & ~skid_valid & (out_take | ~inflight);
    assign imem_en   = issue & ~rst;
    assign imem_addr = pc[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else if (redirect_valid) begin
            // The word returning this cycle belongs to the old stream and is dropped.
            pc          <= redirect_pc;
            inflight    <= 1'b0;
            skid_valid  <= 1'b0;
            if_id_valid <= 1'b0;
        end else begin
            if (issue) begin
                pc          <= pc + 32'd1;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end

            if (out_take) begin
                if (skid_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= skid_instr;
                    if_id_pc    <= skid_pc;
                    skid_valid  <= 1'b0;
                end else if (inflight) begin
                    if_id_valid <= 1'b1;
                    if_id_instr <= imem_dout;
                    if_id_pc    <= inflight_pc;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_dout;
                skid_pc    <= inflight_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenario tasks plus a randomized run, with a stream-order
// reference model (next expected PC, restarted on reset/redirect) checking every word ID accepts.
module tb_fetch_stage;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               rst;
    logic               run_en;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_dout;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               id_ready;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [31:0]        if_id_pc;

    logic [31:0] mem [0:511];
    logic [31:0] exp_pc;
    int pass_cnt;
    int total_cnt;

    fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .run_en         (run_en),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one-cycle latency
    always @(posedge clk) begin
        if (imem_en) imem_dout <= mem[imem_addr];
    end

    // Scoreboard: every accepted word must be the next PC of the current stream
    always @(negedge clk) begin
        logic [8:0] idx;
        if (rst) begin
            exp_pc = 32'h0;
        end else begin
            if (if_id_valid && id_ready) begin
                idx = exp_pc[8:0];
                total_cnt++;
                if (if_id_pc !== exp_pc || if_id_instr !== mem[idx])
                    $display("FAIL scoreboard: got pc=%h instr=%h, expected pc=%h instr=%h",
                             if_id_pc, if_id_instr, exp_pc, mem[idx]);
                else
                    pass_cnt++;
                exp_pc = exp_pc + 32'd1;
            end
            if (redirect_valid) exp_pc = redirect_pc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        total_cnt++;
        if (if_id_valid !== 1'b0 || imem_en !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0)
            $display("FAIL reset_state: valid=%b en=%b pc=%h instr=%h, expected all zero",
                     if_id_valid, imem_en, if_id_pc, if_id_instr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        rst = 1'b0; run_en = 1'b1; id_ready = 1'b1;
        #1;
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd0)
            $display("FAIL stream_first_issue: en=%b addr=%h, expected 1/000", imem_en, imem_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_id_valid !== 1'b0)
            $display("FAIL stream_latency: valid=%b one edge after issue, expected 0", if_id_valid);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            step();
            total_cnt++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(k) || if_id_instr !== 32'hA000_0000 + 32'(k))
                $display("FAIL stream_word: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                         if_id_valid, if_id_pc, if_id_instr, k, 32'hA000_0000 + 32'(k));
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        id_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if (imem_en !== 1'b0)
                $display("FAIL stall_no_issue: en=%b while stalled, expected 0", imem_en);
            else pass_cnt++;
            step();
            total_cnt++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'd7 || if_id_instr !== 32'hA000_0007)
                $display("FAIL stall_hold: valid=%b pc=%h instr=%h, expected 1 pc=7 instr=a0000007",
                         if_id_valid, if_id_pc, if_id_instr);
            else pass_cnt++;
        end
        id_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (if_id_valid) got.push_back(if_id_pc);
            step();
        end
        total_cnt++;
        if (got.size() != 4)
            $display("FAIL stall_release_count: got %0d words, expected 4", got.size());
        else pass_cnt++;
        for (int i = 0; i < got.size(); i++) begin
            total_cnt++;
            if (got[i] !== 32'd7 + 32'(i))
                $display("FAIL stall_release_order: word %0d pc=%h, expected %h", i, got[i], 32'd7 + 32'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        total_cnt++;
        if (imem_en !== 1'b0)
            $display("FAIL redirect_no_issue: en=%b in redirect cycle, expected 0", imem_en);
        else pass_cnt++;
        step();
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (if_id_valid !== 1'b0)
            $display("FAIL redirect_flush: valid=%b, expected 0", if_id_valid);
        else pass_cnt++;
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 9'h40)
            $display("FAIL redirect_issue: en=%b addr=%h, expected 1/040", imem_en, imem_addr);
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== 32'hA000_0040)
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h, expected 1 pc=40 instr=a0000040",
                     if_id_valid, if_id_pc, if_id_instr);
        else pass_cnt++;
        id_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_wrap();
        logic [31:0] gpc[$];
        logic [31:0] gin[$];
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1FF;
        step();
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 9'h1FF)
            $display("FAIL wrap_addr_1ff: en=%b addr=%h, expected 1/1ff", imem_en, imem_addr);
        else pass_cnt++;
        for (int c = 0; c < 12 && gpc.size() < 2; c++) begin
            if (c == 1) begin
                total_cnt++;
                if (imem_en !== 1'b1 || imem_addr !== 9'h000)
                    $display("FAIL wrap_addr_0: en=%b addr=%h, expected 1/000", imem_en, imem_addr);
                else pass_cnt++;
            end
            if (if_id_valid) begin gpc.push_back(if_id_pc); gin.push_back(if_id_instr); end
            step();
        end
        total_cnt++;
        if (gpc.size() != 2 || gpc[0] !== 32'h1FF || gin[0] !== 32'hA000_01FF ||
            gpc[1] !== 32'h200 || gin[1] !== 32'hA000_0000)
            $display("FAIL wrap_words: got %0d words, expected pc 1ff/a00001ff then 200/a0000000", gpc.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [31:0] first_pc;
        logic [31:0] first_in;
        logic        seen;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (if_id_valid !== 1'b0 || imem_en !== 1'b0 || if_id_pc !== 32'h0)
            $display("FAIL async_reset: valid=%b en=%b pc=%h, expected 0/0/0", if_id_valid, imem_en, if_id_pc);
        else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 9'd0)
            $display("FAIL reset_restart_issue: en=%b addr=%h, expected 1/000", imem_en, imem_addr);
        else pass_cnt++;
        seen = 1'b0; first_pc = 'x; first_in = 'x;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (if_id_valid) begin seen = 1'b1; first_pc = if_id_pc; first_in = if_id_instr; end
            else step();
        end
        total_cnt++;
        if (!seen || first_pc !== 32'h0 || first_in !== 32'hA000_0000)
            $display("FAIL reset_restart_word: seen=%b pc=%h instr=%h, expected pc=0 instr=a0000000",
                     seen, first_pc, first_in);
        else pass_cnt++;
    endtask

    task automatic test_run_en_drop();
        logic [31:0] got[$];
        id_ready = 1'b1; run_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (imem_en !== 1'b1 || imem_addr !== 9'h100 + 9'(i))
                $display("FAIL run_issue: en=%b addr=%h, expected 1/%h", imem_en, imem_addr, 9'h100 + 9'(i));
            else pass_cnt++;
            if (if_id_valid) got.push_back(if_id_pc);
            step();
        end
        run_en = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            total_cnt++;
            if (imem_en !== 1'b0)
                $display("FAIL run_off_no_issue: en=%b, expected 0", imem_en);
            else pass_cnt++;
            if (if_id_valid) got.push_back(if_id_pc);
            step();
        end
        total_cnt++;
        if (got.size() != 3 || got[0] !== 32'h100 || got[2] !== 32'h102)
            $display("FAIL run_off_drain: got %0d words, expected 3 (pc 100..102)", got.size());
        else pass_cnt++;
        total_cnt++;
        if (if_id_valid !== 1'b0)
            $display("FAIL run_off_idle: valid=%b, expected 0", if_id_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        p_valid, p_ready, p_redir;
        logic [31:0] p_pc, p_instr;
        int          accepted;
        accepted = 0;
        p_valid = 1'b0; p_ready = 1'b1; p_redir = 1'b0; p_pc = '0; p_instr = '0;
        for (int c = 0; c < 400; c++) begin
            if (p_valid && !p_ready && !p_redir) begin
                total_cnt++;
                if (if_id_valid !== 1'b1 || if_id_pc !== p_pc || if_id_instr !== p_instr)
                    $display("FAIL rand_stall_stable: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                             if_id_valid, if_id_pc, if_id_instr, p_pc, p_instr);
                else pass_cnt++;
            end
            id_ready       = ($urandom_range(0, 9) < 7);
            run_en         = ($urandom_range(0, 19) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom;
            if (if_id_valid && id_ready) accepted++;
            p_valid = if_id_valid; p_ready = id_ready; p_redir = redirect_valid;
            p_pc = if_id_pc; p_instr = if_id_instr;
            step();
        end
        redirect_valid = 1'b0; run_en = 1'b0; id_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        total_cnt++;
        if (if_id_valid !== 1'b0 || accepted < 50)
            $display("FAIL rand_drain: valid=%b accepted=%0d, expected 0 and at least 50", if_id_valid, accepted);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        imem_dout = '0;
        for (int k = 0; k < 512; k++) mem[k] = 32'hA000_0000 + 32'(k);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_run_en_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
